// File: rtl/beep_pkg.sv
// Shared types and pattern decoding for the beeper arbiter.
// Used unchanged whether or not BEEP_ABORT_EN is defined.
package beep_pkg;

  typedef enum logic [1:0] {
    PAT_SHORT1 = 2'd0,
    PAT_LONG1  = 2'd1,
    PAT_SHORT2 = 2'd2,
    PAT_SHORT3 = 2'd3
  } pat_code_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_TONE = 2'd1,
    ST_GAP  = 2'd2
  } state_e;

  typedef struct packed {
    logic [1:0] count;
    logic       is_long;
  } pat_info_t;

  function automatic pat_info_t decode_pattern(input pat_code_e code);
    pat_info_t info;
    info = '{count: 2'd1, is_long: 1'b0};
    case (code)
      PAT_SHORT1: info = '{count: 2'd1, is_long: 1'b0};
      PAT_LONG1:  info = '{count: 2'd1, is_long: 1'b1};
      PAT_SHORT2: info = '{count: 2'd2, is_long: 1'b0};
      PAT_SHORT3: info = '{count: 2'd3, is_long: 1'b0};
    endcase
    return info;
  endfunction

endpackage

// File: rtl/tone_gen.sv
// Square-wave generator: the output starts high on restart and toggles
// every HALF_PER_CYC enabled cycles.
module tone_gen #(
  parameter int HALF_PER_CYC = 100000
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic restart,
  output logic wave
);

  logic [31:0] half_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      half_cnt <= '0;
      wave     <= 1'b0;
    end else if (restart) begin
      half_cnt <= '0;
      wave     <= 1'b1;
    end else if (en) begin
      if (half_cnt == 32'(HALF_PER_CYC - 1)) begin
        half_cnt <= '0;
        wave     <= ~wave;
      end else begin
        half_cnt <= half_cnt + 32'd1;
      end
    end
  end

endmodule

// File: rtl/beep_arbiter.sv
// Round-robin arbiter that shares one beeper among N_CH channels.
// It plays coded tone/gap patterns. Defining BEEP_ABORT_EN adds the abort input and the aborted output.
module beep_arbiter
  import beep_pkg::*;
#(
  parameter int N_CH         = 4,
  parameter int HALF_PER_CYC = 100000,
  parameter int SHORT_CYC    = 10000000,
  parameter int LONG_CYC     = 50000000,
  parameter int GAP_CYC      = 10000000
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N_CH-1:0]         req,
  input  logic [2*N_CH-1:0]       pattern,
`ifdef BEEP_ABORT_EN
  input  logic                    abort,
  output logic                    aborted,
`endif
  output logic [N_CH-1:0]         ack,
  output logic                    busy,
  output logic [$clog2(N_CH)-1:0] active_ch,
  output logic                    done,
  output logic                    beep
);

  localparam int PW = $clog2(N_CH);

  state_e        state;
  logic [31:0]   seg_cnt;
  logic [1:0]    tones_left;
  logic          is_long;
  logic [PW-1:0] ptr;

  logic [N_CH-1:0] req_rot;
  logic [PW:0]     scan_sum;
  logic            grant_valid;
  logic [PW-1:0]   grant_idx;
  logic [N_CH-1:0] grant_onehot;
  logic [1:0]      grant_code;
  pat_info_t       grant_info;
  logic [PW:0]     ptr_inc;
  logic [PW-1:0]   ptr_next;

  logic abort_now;
  logic tone_last;
  logic gap_last;
  logic restart;
  logic wave;

  // Rotate requests so that bit 0 is the pointer's channel; the lowest set bit wins.
  always_comb begin
    req_rot     = N_CH'({req, req} >> ptr);
    grant_valid = 1'b0;
    grant_idx   = '0;
    scan_sum    = '0;
    for (int k = 0; k < N_CH; k++) begin
      if (!grant_valid && req_rot[k]) begin
        grant_valid = 1'b1;
        scan_sum    = {1'b0, ptr} + (PW+1)'(k);
        if (scan_sum >= (PW+1)'(N_CH)) begin
          scan_sum = scan_sum - (PW+1)'(N_CH);
        end
        grant_idx = scan_sum[PW-1:0];
      end
    end
  end

  assign grant_onehot = {{(N_CH-1){1'b0}}, 1'b1} << grant_idx;
  assign grant_code   = 2'(pattern >> {grant_idx, 1'b0});
  assign grant_info   = decode_pattern(pat_code_e'(grant_code));
  assign ptr_inc      = {1'b0, grant_idx} + (PW+1)'(1);
  assign ptr_next     = (ptr_inc == (PW+1)'(N_CH)) ? '0 : ptr_inc[PW-1:0];

`ifdef BEEP_ABORT_EN
  assign abort_now = abort;
`else
  assign abort_now = 1'b0;
`endif

  assign tone_last = (seg_cnt == (is_long ? 32'(LONG_CYC - 1) : 32'(SHORT_CYC - 1)));
  assign gap_last  = (seg_cnt == 32'(GAP_CYC - 1));
  assign restart   = ((state == ST_IDLE) && grant_valid) ||
                     ((state == ST_GAP) && gap_last && !abort_now);

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      seg_cnt    <= '0;
      tones_left <= '0;
      is_long    <= 1'b0;
      ptr        <= '0;
      active_ch  <= '0;
      ack        <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      ack  <= '0;
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (grant_valid) begin
            state      <= ST_TONE;
            seg_cnt    <= '0;
            ack        <= grant_onehot;
            tones_left <= grant_info.count;
            is_long    <= grant_info.is_long;
            active_ch  <= grant_idx;
            busy       <= 1'b1;
            ptr        <= ptr_next;
          end
        end
        ST_TONE: begin
          if (abort_now) begin
            state   <= ST_IDLE;
            seg_cnt <= '0;
            busy    <= 1'b0;
          end else if (tone_last) begin
            seg_cnt <= '0;
            if (tones_left > 2'd1) begin
              tones_left <= tones_left - 2'd1;
              state      <= ST_GAP;
            end else begin
              state <= ST_IDLE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end
          end else begin
            seg_cnt <= seg_cnt + 32'd1;
          end
        end
        ST_GAP: begin
          if (abort_now) begin
            state   <= ST_IDLE;
            seg_cnt <= '0;
            busy    <= 1'b0;
          end else if (gap_last) begin
            seg_cnt <= '0;
            state   <= ST_TONE;
          end else begin
            seg_cnt <= seg_cnt + 32'd1;
          end
        end
        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

`ifdef BEEP_ABORT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      aborted <= 1'b0;
    end else begin
      aborted <= abort && (state != ST_IDLE);
    end
  end
`endif

  tone_gen #(
    .HALF_PER_CYC(HALF_PER_CYC)
  ) u_tone_gen (
    .clk     (clk),
    .rst     (rst),
    .en      (state == ST_TONE),
    .restart (restart),
    .wave    (wave)
  );

  assign beep = wave & (state == ST_TONE);

endmodule

// File: tb/tb_beep_arbiter.sv
// Self-checking bench for beep_arbiter: directed vectors plus randomized traffic against a waveform-queue model.
// The abort port and its checks are present only when BEEP_ABORT_EN is defined.
module tb_beep_arbiter;

  localparam int N_CH  = 4;
  localparam int HALF  = 2;
  localparam int SHORT = 8;
  localparam int LONG  = 20;
  localparam int GAP   = 4;
`ifdef BEEP_ABORT_EN
  localparam bit ABORT_ON = 1'b1;
`else
  localparam bit ABORT_ON = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] req = '0;
  logic [7:0] pattern = '0;
  logic [3:0] ack;
  logic       busy;
  logic [1:0] active_ch;
  logic       done;
  logic       beep;
`ifdef BEEP_ABORT_EN
  logic       abort = 1'b0;
  logic       aborted;
`endif

  beep_arbiter #(
    .N_CH(N_CH), .HALF_PER_CYC(HALF), .SHORT_CYC(SHORT),
    .LONG_CYC(LONG), .GAP_CYC(GAP)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .pattern   (pattern),
`ifdef BEEP_ABORT_EN
    .abort     (abort),
    .aborted   (aborted),
`endif
    .ack       (ack),
    .busy      (busy),
    .active_ch (active_ch),
    .done      (done),
    .beep      (beep)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Model: queue of beep values still to be played by the current pattern.
  bit         exp_q[$];
  logic [3:0] e_ack = '0;
  logic       e_done = 1'b0;
  logic       e_ab = 1'b0;
  logic [1:0] e_act = '0;
  int         m_ptr = 0;

  typedef struct {
    logic [3:0] req;
    logic [7:0] pattern;
    logic [3:0] ack;
    logic       busy;
    logic       beep;
    logic       done;
    logic [1:0] act;
  } vec_t;

  vec_t tbl[11];

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_tests++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s at %0t: got %0h, expected %0h", name, $time, actual, expected);
    end
  endtask

  task automatic loadPattern(input logic [1:0] code);
    int n;
    int len;
    n   = (code == 2'd3) ? 3 : (code == 2'd2) ? 2 : 1;
    len = (code == 2'd1) ? LONG : SHORT;
    for (int t = 0; t < n; t++) begin
      for (int c = 0; c < len; c++) exp_q.push_back(((c / HALF) % 2) == 0);
      if (t < n - 1) begin
        for (int c = 0; c < GAP; c++) exp_q.push_back(1'b0);
      end
    end
  endtask

  task automatic modelStep(input logic r, input logic [3:0] rq, input logic [7:0] pat, input logic ab);
    e_ack  = '0;
    e_done = 1'b0;
    e_ab   = 1'b0;
    if (r) begin
      exp_q.delete();
      m_ptr = 0;
      e_act = '0;
    end else if (exp_q.size() > 0) begin
      void'(exp_q.pop_front());
      if (ab) begin
        exp_q.delete();
        e_ab = 1'b1;
      end else if (exp_q.size() == 0) begin
        e_done = 1'b1;
      end
    end else begin
      for (int k = 0; k < N_CH; k++) begin
        int g;
        g = (m_ptr + k) % N_CH;
        if (e_ack == 4'b0000 && rq[g]) begin
          e_ack[g] = 1'b1;
          e_act    = 2'(g);
          m_ptr    = (g + 1) % N_CH;
          loadPattern(2'(pat >> (2 * g)));
        end
      end
    end
  endtask

  task automatic checkModel();
    checkOutput("beep", beep, (exp_q.size() > 0) ? exp_q[0] : 1'b0);
    checkOutput("busy", busy, exp_q.size() > 0);
    checkOutput("ack", ack, e_ack);
    checkOutput("done", done, e_done);
    if (exp_q.size() > 0) checkOutput("active_ch", active_ch, e_act);
`ifdef BEEP_ABORT_EN
    checkOutput("aborted", aborted, e_ab);
`endif
  endtask

  // Drive one cycle of inputs, advance the model, then check after the edge.
  task automatic applyStimulus(input logic r, input logic [3:0] rq, input logic [7:0] pat, input logic ab);
    rst     = r;
    req     = rq;
    pattern = pat;
`ifdef BEEP_ABORT_EN
    abort   = ab;
`endif
    modelStep(r, rq, pat, ab & ABORT_ON);
    @(posedge clk);
    #1;
    checkModel();
  endtask

  initial begin
    logic [19:0] p2_wave;
    int          n_done;
    logic [3:0]  hold;

    tbl[0]  = '{4'b0010, 8'h00, 4'b0000, 1'b0, 1'b0, 1'b0, 2'd0};
    tbl[1]  = '{4'b0000, 8'h00, 4'b0010, 1'b1, 1'b1, 1'b0, 2'd1};
    tbl[2]  = '{4'b0000, 8'h00, 4'b0000, 1'b1, 1'b1, 1'b0, 2'd1};
    tbl[3]  = '{4'b0000, 8'h00, 4'b0000, 1'b1, 1'b0, 1'b0, 2'd1};
    tbl[4]  = '{4'b0000, 8'h00, 4'b0000, 1'b1, 1'b0, 1'b0, 2'd1};
    tbl[5]  = '{4'b0000, 8'h00, 4'b0000, 1'b1, 1'b1, 1'b0, 2'd1};
    tbl[6]  = '{4'b0000, 8'h00, 4'b0000, 1'b1, 1'b1, 1'b0, 2'd1};
    tbl[7]  = '{4'b0000, 8'h00, 4'b0000, 1'b1, 1'b0, 1'b0, 2'd1};
    tbl[8]  = '{4'b0000, 8'h00, 4'b0000, 1'b1, 1'b0, 1'b0, 2'd1};
    tbl[9]  = '{4'b0000, 8'h00, 4'b0000, 1'b0, 1'b0, 1'b1, 2'd0};
    tbl[10] = '{4'b0000, 8'h00, 4'b0000, 1'b0, 1'b0, 1'b0, 2'd0};

    @(posedge clk);
    #1;
    applyStimulus(1'b1, 4'b0000, 8'h00, 1'b0);
    applyStimulus(1'b1, 4'b0000, 8'h00, 1'b0);
    checkOutput("reset_beep", beep, 1'b0);
    checkOutput("reset_busy", busy, 1'b0);
    checkOutput("reset_ack", ack, 4'b0000);
    checkOutput("reset_done", done, 1'b0);
    checkOutput("reset_active_ch", active_ch, 2'd0);
    applyStimulus(1'b0, 4'b0000, 8'h00, 1'b0);

    // Single short tone on channel 1, cycle by cycle.
    for (int i = 0; i < 11; i++) begin
      checkOutput("tbl_ack", ack, tbl[i].ack);
      checkOutput("tbl_busy", busy, tbl[i].busy);
      checkOutput("tbl_beep", beep, tbl[i].beep);
      checkOutput("tbl_done", done, tbl[i].done);
      if (tbl[i].busy) checkOutput("tbl_active_ch", active_ch, tbl[i].act);
      applyStimulus(1'b0, tbl[i].req, tbl[i].pattern, 1'b0);
    end

    // Two short tones on channel 2, with the pattern inputs scrambled during playback.
    p2_wave = 20'b11001100_0000_11001100;
    n_done  = 0;
    applyStimulus(1'b0, 4'b0100, 8'h20, 1'b0);
    checkOutput("p2_ack", ack, 4'b0100);
    checkOutput("p2_active_ch", active_ch, 2'd2);
    for (int i = 0; i < 20; i++) begin
      checkOutput("p2_beep", beep, p2_wave[19-i]);
      checkOutput("p2_busy", busy, 1'b1);
      if (done) n_done++;
      applyStimulus(1'b0, 4'b0000, 8'($urandom), 1'b0);
    end
    checkOutput("p2_early_done", n_done, 0);
    checkOutput("p2_done", done, 1'b1);
    checkOutput("p2_busy_end", busy, 1'b0);
    applyStimulus(1'b0, 4'b0000, 8'h00, 1'b0);
    checkOutput("p2_done_once", done, 1'b0);

    // Round robin from reset: ch0 then ch3, then ch0 again.
    applyStimulus(1'b1, 4'b1001, 8'h00, 1'b0);
    checkOutput("rr_reset_ack", ack, 4'b0000);
    applyStimulus(1'b0, 4'b1001, 8'h00, 1'b0);
    checkOutput("rr_first_ack", ack, 4'b0001);
    for (int i = 0; i < 8; i++) applyStimulus(1'b0, 4'b1000, 8'h00, 1'b0);
    checkOutput("rr_ch0_done", done, 1'b1);
    checkOutput("rr_no_ack_with_done", ack, 4'b0000);
    applyStimulus(1'b0, 4'b1000, 8'h00, 1'b0);
    checkOutput("rr_second_ack", ack, 4'b1000);
    checkOutput("rr_second_active_ch", active_ch, 2'd3);
    for (int i = 0; i < 8; i++) applyStimulus(1'b0, 4'b0000, 8'h00, 1'b0);
    checkOutput("rr_ch3_done", done, 1'b1);
    applyStimulus(1'b0, 4'b1001, 8'h00, 1'b0);
    checkOutput("rr_wrap_ack", ack, 4'b0001);

    // Channel 1 requests while channel 0 plays and must wait until after done.
    applyStimulus(1'b0, 4'b0000, 8'h00, 1'b0);
    for (int i = 0; i < 7; i++) begin
      applyStimulus(1'b0, 4'b0010, 8'h00, 1'b0);
      checkOutput("wait_no_ack", ack, 4'b0000);
    end
    checkOutput("wait_done", done, 1'b1);
    applyStimulus(1'b0, 4'b0010, 8'h00, 1'b0);
    checkOutput("wait_ack", ack, 4'b0010);
    for (int i = 0; i < 8; i++) applyStimulus(1'b0, 4'b0000, 8'h00, 1'b0);
    checkOutput("wait_ch1_done", done, 1'b1);

    // Reset during the first gap of a three-tone pattern.
    applyStimulus(1'b0, 4'b0010, 8'h0C, 1'b0);
    checkOutput("gap_ack", ack, 4'b0010);
    for (int i = 0; i < 9; i++) applyStimulus(1'b0, 4'b0000, 8'h0C, 1'b0);
    checkOutput("gap_beep_low", beep, 1'b0);
    checkOutput("gap_busy", busy, 1'b1);
    applyStimulus(1'b1, 4'b0000, 8'h00, 1'b0);
    checkOutput("gaprst_beep", beep, 1'b0);
    checkOutput("gaprst_busy", busy, 1'b0);
    checkOutput("gaprst_done", done, 1'b0);
    checkOutput("gaprst_ack", ack, 4'b0000);
    applyStimulus(1'b0, 4'b0000, 8'h00, 1'b0);
    checkOutput("gaprst_done_after", done, 1'b0);
    applyStimulus(1'b0, 4'b1010, 8'h00, 1'b0);
    checkOutput("gaprst_ptr_zero", ack, 4'b0010);
    for (int i = 0; i < 9; i++) applyStimulus(1'b0, 4'b0000, 8'h00, 1'b0);

`ifdef BEEP_ABORT_EN
    // Abort on the third cycle of a long tone.
    applyStimulus(1'b0, 4'b0001, 8'h01, 1'b0);
    checkOutput("abort_ack", ack, 4'b0001);
    applyStimulus(1'b0, 4'b0000, 8'h01, 1'b0);
    applyStimulus(1'b0, 4'b0000, 8'h01, 1'b0);
    applyStimulus(1'b0, 4'b0000, 8'h01, 1'b1);
    checkOutput("abort_beep", beep, 1'b0);
    checkOutput("abort_busy", busy, 1'b0);
    checkOutput("abort_pulse", aborted, 1'b1);
    checkOutput("abort_no_done", done, 1'b0);
    applyStimulus(1'b0, 4'b0000, 8'h00, 1'b0);
    checkOutput("abort_pulse_end", aborted, 1'b0);
    checkOutput("abort_no_done_later", done, 1'b0);
`endif

    // Randomized traffic: requesters hold req until the model's expected ack.
    hold = '0;
    for (int c = 0; c < 4000; c++) begin
      hold = hold & ~e_ack;
      for (int ch = 0; ch < N_CH; ch++) begin
        if (!hold[ch] && $urandom_range(0, 7) == 0) hold[ch] = 1'b1;
      end
      applyStimulus($urandom_range(0, 299) == 0, hold, 8'($urandom),
                    $urandom_range(0, 59) == 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/beep_arbiter.md
Name: beep_arbiter

Overview:
- Shares the single front-panel beeper among N_CH answering-machine channels.
- Each channel requests a coded beep pattern through a req/ack handshake. Round-robin arbitration picks one channel at a time.
- An FSM sequences tone and silence segments and drives the square-wave output.
- Replaces per-channel free-running beepers. Sits between the channel controllers and the buzzer pin.

Parameters:
- N_CH, 4: number of requesting channels (2..8).
- HALF_PER_CYC, 100000: clk cycles per tone half-period (500 Hz at 100 MHz).
- SHORT_CYC, 10000000: short tone length in cycles (100 ms).
- LONG_CYC, 50000000: long tone length in cycles (500 ms).
- GAP_CYC, 10000000: silence between tones in a multi-tone pattern.

Ports:
- clk  in  1  system clock; the only clock.
- rst  in  1  synchronous, active-high reset.
- req  in  N_CH  per-channel request; held high until ack.
- pattern  in  2*N_CH  per-channel code, channel i at [2i+1:2i]:
  - 0 = one short tone
  - 1 = one long tone
  - 2 = two short tones
  - 3 = three short tones
- ack  out  N_CH  one-cycle grant pulse; pattern is sampled at this edge.
- busy  out  1  high while a pattern is playing.
- active_ch  out  clog2(N_CH)  index of the granted channel; valid while busy.
- done  out  1  one-cycle pulse when a pattern completes.
- beep  out  1  buzzer drive.

Behaviour:
- Reset:
  - All outputs are 0; FSM goes to IDLE; round-robin pointer is 0.
  - Reset asserted mid-pattern: beep is 0 at the next edge, the pattern is discarded, and no done pulse is issued.
- States:
  - IDLE, TONE, GAP.
  - Segment counter (32 b) counts cycles within the current segment.
  - Tones-remaining counter (2 b).
- Arbitration:
  - Evaluated only in IDLE.
  - The first req found scanning from the pointer upward, wrapping modulo N_CH, wins.
  - At that edge:
    - state becomes TONE
    - ack[g] = 1 for exactly one cycle
    - pattern[g] is latched and decoded to tone count (1,1,2,3) and tone length (SHORT, LONG, SHORT, SHORT)
    - active_ch = g, busy = 1
    - pointer = g+1 mod N_CH
  - Latency: req high in an IDLE cycle k gives ack in cycle k+1.
  - A req asserted while busy waits; it is never dropped.
  - Requesters deassert req on seeing ack. Because the FSM has left IDLE, the same request cannot be granted twice.
- TONE:
  - Lasts exactly the tone length in cycles.
  - beep = 1 on the first TONE cycle, then toggles every HALF_PER_CYC cycles.
  - On the last cycle of the segment:
    - if tones remaining > 1: decrement and go to GAP
    - otherwise: go to IDLE and pulse done with busy = 0
- GAP: beep = 0 for GAP_CYC cycles, then TONE with the half-period counter restarted (beep = 1 again).
- beep is 0 in IDLE and GAP.
- done and ack never occur in the same cycle. The earliest next grant is the cycle after done.
- Changes to pattern inputs during a playback have no effect.

Optional Feature:
- Macro: BEEP_ABORT_EN.
- With the macro defined:
  - Adds input abort (1 b).
  - abort high in TONE or GAP gives IDLE at the next edge: beep = 0, busy = 0, no done pulse.
  - Adds output aborted (1 b), which pulses for one cycle instead of done.
  - abort in IDLE is ignored.
  - abort in the same cycle as the last segment cycle takes precedence, so aborted pulses rather than done.
- Without the macro: neither port exists and patterns always run to completion.

Decomposition:
- Package beep_pkg:
  - pattern code enum
  - FSM state enum
  - decode function from code to {count, length selector}
- Sub-module tone_gen:
  - half-period counter with enable and synchronous restart
  - outputs the square wave
  - instantiated once; beep = tone_gen output AND (state == TONE)

Test Plan (HALF_PER_CYC = 2, SHORT_CYC = 8, LONG_CYC = 20, GAP_CYC = 4, N_CH = 4):
- req[1] = 1, pattern = 0 in IDLE:
  - ack[1] next cycle; busy for 8 cycles
  - beep = 1,1,0,0,1,1,0,0
  - done one cycle after the last tone cycle; active_ch = 1
- req[2] = 1, pattern = 2: beep over 20 cycles is tone(8), zeros(4), tone(8) with the second tone starting at 1; single done.
- req[0] and req[3] asserted together from reset:
  - ch0 granted first, ch3 after ch0's done
  - then re-request both: ch0 granted again (pointer was 0 after ch3 was served)
- req[1] asserted mid-playback of ch0: no ack until the cycle after ch0's done; ack then arrives with no lost request.
- rst high during the GAP of pattern 3: beep, busy and done are all 0 next cycle; ack is 0 and pointer is 0 after release.
- BEEP_ABORT_EN: abort pulsed on TONE cycle 3 of pattern 1 gives IDLE next cycle, beep = 0, aborted pulse, no done.
